// File: rtl/spi_register_interface_pkg.sv
// Shared constants and types for the SPI register interface.
// The line idle levels double as the synchronizer reset values.
package spi_register_interface_pkg;

  localparam int SPI_FRAME_BITS = 32;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT,
    DRAIN
  } SpiState_t;

  localparam logic SPI_SCK_IDLE  = 1'b0;
  localparam logic SPI_CSN_IDLE  = 1'b1;
  localparam logic SPI_MOSI_IDLE = 1'b0;

endpackage

// File: rtl/spi_register_interface_input_synchronizer.sv
// Flop chain that brings one asynchronous SPI pin into the i_Clock domain.
module input_synchronizer #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Async,
  output logic o_Sync
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) chain_q <= {STAGES{RESET_VAL}};
    else         chain_q <= {chain_q[STAGES-2:0], i_Async};
  end

  assign o_Sync = chain_q[STAGES-1];

endmodule

// File: rtl/spi_register_interface.sv
// SPI mode-0 slave: oversamples SCK/CS_N/MOSI, assembles 32-bit frames into
// register writes and echoes the last accepted frame on MISO.
module spi_register_interface
  import spi_register_interface_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_SpiClock,
  input  logic                  i_SpiChipSelectN,
  input  logic                  i_SpiMosi,
  output logic                  o_SpiMiso,
  output logic [ADDR_WIDTH-1:0] o_RegisterNumber,
  output logic [DATA_WIDTH-1:0] o_RegisterValue,
  output logic                  o_RegisterWriteEnable,
  output logic                  o_FrameError
);

  localparam int FRAME_BITS = ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [2:0] IDLE_LVL = {SPI_MOSI_IDLE, SPI_CSN_IDLE, SPI_SCK_IDLE};

  logic [2:0] pins_raw, pins_sync;
  logic       sck_s, csn_s, mosi_s, sck_prev_q, rise, fall;

  assign pins_raw = {i_SpiMosi, i_SpiChipSelectN, i_SpiClock};

  for (genvar g = 0; g < 3; g++) begin : g_sync
    input_synchronizer #(
      .STAGES   (SYNC_STAGES),
      .RESET_VAL(IDLE_LVL[g])
    ) u_sync (
      .i_Clock(i_Clock),
      .i_Reset(i_Reset),
      .i_Async(pins_raw[g]),
      .o_Sync (pins_sync[g])
    );
  end

  assign {mosi_s, csn_s, sck_s} = pins_sync;
  assign rise = sck_s & ~sck_prev_q;
  assign fall = ~sck_s & sck_prev_q;

  SpiState_t             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] rx_q, rx_d, tx_q, tx_d;
  logic [ADDR_WIDTH-1:0] num_q, num_d;
  logic [DATA_WIDTH-1:0] val_q, val_d;
  logic                  we_q, we_d, err_q, err_d;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q    <= WAIT_IDLE;
      sck_prev_q <= SPI_SCK_IDLE;
      cnt_q      <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      num_q      <= '0;
      val_q      <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sck_prev_q <= sck_s;
      cnt_q      <= cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      num_q      <= num_d;
      val_q      <= val_d;
      we_q       <= we_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    num_d   = num_q;
    val_d   = val_q;
    we_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      // The chain's reset value is not a real CS observation; let the
      // actual pin level reach the synchronizer output before trusting it.
      WAIT_IDLE: begin
        if (cnt_q < CNT_W'(SYNC_STAGES)) cnt_d = cnt_q + 1'b1;
        else if (csn_s)                  state_d = IDLE;
      end
      IDLE: begin
        cnt_d = '0;
        tx_d  = {num_q, val_q};
        if (!csn_s) state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(FRAME_BITS)) begin
          num_d   = rx_q[FRAME_BITS-1 -: ADDR_WIDTH];
          val_d   = rx_q[DATA_WIDTH-1:0];
          we_d    = 1'b1;
          state_d = DRAIN;
        end else if (csn_s) begin
          // CS release beats a coincident SCK rise
          err_d   = (cnt_q != '0);
          state_d = IDLE;
        end else if (rise) begin
          rx_d  = {rx_q[FRAME_BITS-2:0], mosi_s};
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (csn_s) state_d = IDLE;
      end
      default: state_d = WAIT_IDLE;
    endcase
    if (fall && (state_q == SHIFT || state_q == DRAIN)) tx_d = tx_q << 1;
  end

  assign o_SpiMiso             = ~csn_s & tx_q[FRAME_BITS-1];
  assign o_RegisterNumber      = num_q;
  assign o_RegisterValue       = val_q;
  assign o_RegisterWriteEnable = we_q;
  assign o_FrameError          = err_q;

endmodule

// File: tb/tb_spi_register_interface.sv
// Randomized and directed SPI frames checked cycle-by-cycle against a
// frame-level model (event queue of predicted strobes plus echo word).
module tb_spi_register_interface;

  localparam int S    = 2;
  localparam int HALF = 4;

  logic        clk = 1'b0, rst = 1'b1, sck = 1'b0, csn = 1'b1, mosi = 1'b0;
  logic        miso, we, err;
  logic [15:0] num, val;

  spi_register_interface #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .SYNC_STAGES(S)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_SpiClock(sck), .i_SpiChipSelectN(csn),
    .i_SpiMosi(mosi), .o_SpiMiso(miso), .o_RegisterNumber(num),
    .o_RegisterValue(val), .o_RegisterWriteEnable(we), .o_FrameError(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    bit          wr;
    logic [31:0] word;
  } ev_t;

  ev_t         evq[$];
  logic [31:0] acc, cur, echo, got_miso, rxw;
  bit          fvalid;
  int          nbits, last_rise, last_we, we_seen, err_seen;
  int          n_checks = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against predicted strobes and visible register contents.
  ev_t ev;
  bit  exp_we, exp_err;
  always @(posedge clk) begin
    #1;
    exp_we  = 1'b0;
    exp_err = 1'b0;
    if (evq.size() > 0 && evq[0].at == cyc) begin
      ev = evq.pop_front();
      if (ev.wr) begin
        exp_we = 1'b1;
        cur    = ev.word;
      end else exp_err = 1'b1;
    end
    chk("we", 32'(we), 32'(exp_we));
    chk("err", 32'(err), 32'(exp_err));
    chk("num", 32'(num), 32'(cur[31:16]));
    chk("val", 32'(val), 32'(cur[15:0]));
    if (we) begin
      last_we = cyc;
      we_seen++;
    end
    if (err) err_seen++;
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_frame();
    csn      = 1'b0;
    echo     = fvalid ? acc : 32'h0;
    nbits    = 0;
    got_miso = 32'h0;
    wait_n(HALF);
  endtask

  task automatic send_bit(input logic b);
    logic exp;
    mosi = b;
    wait_n(HALF);
    exp = (fvalid && nbits < 32) ? echo[31-nbits] : 1'b0;
    chk("miso", 32'(miso), 32'(exp));
    if (nbits < 32) got_miso[31-nbits] = miso;
    sck       = 1'b1;
    last_rise = cyc + 1;
    nbits++;
    // First 32 bits form {number, value}; strobe S+1 edges after the sampling edge
    if (fvalid && nbits == 32) begin
      evq.push_back('{cyc + S + 2, 1'b1, rxw});
      acc = rxw;
    end
    wait_n(HALF);
    sck = 1'b0;
  endtask

  task automatic end_frame(input int gap);
    wait_n(HALF);
    csn = 1'b1;
    if (fvalid && nbits > 0 && nbits < 32) evq.push_back('{cyc + S + 1, 1'b0, 32'h0});
    wait_n(gap);
    fvalid = 1'b1;
  endtask

  task automatic send_frame(input logic [31:0] w, input int n, input int gap);
    logic b;
    rxw = w;
    start_frame();
    for (int i = 0; i < n; i++) begin
      if (i < 32) b = w[31-i];
      else        b = 1'($urandom_range(0, 1));
      send_bit(b);
    end
    end_frame(gap);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    evq.delete();
    acc    = 32'h0;
    cur    = 32'h0;
    echo   = 32'h0;
    fvalid = 1'b0;
    wait_n(2);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  int w0, e0;
  initial begin
    acc = 32'h0; cur = 32'h0; fvalid = 1'b0; we_seen = 0; err_seen = 0;
    last_we = 0; last_rise = 0;
    wait_n(3);
    chk("reset_num", 32'(num), 32'h0);
    chk("reset_miso", 32'(miso), 32'h0);
    rst = 1'b0;
    wait_n(6);
    fvalid = 1'b1;

    // single write with latency pin
    w0 = we_seen;
    send_frame(32'h0101_0001, 32, 6);
    chk("single_num", 32'(num), 32'h0101);
    chk("single_val", 32'(val), 32'h0001);
    chk("single_cnt", 32'(we_seen - w0), 32'd1);
    chk("single_lat", 32'(last_we - last_rise), 32'd3);

    // echo of the previous frame
    send_frame(32'h0000_0000, 32, 6);
    chk("echo_word", got_miso, 32'h0101_0001);
    chk("echo_num", 32'(num), 32'h0);

    // overlong frame
    w0 = we_seen;
    send_frame(32'h1203_ABCD, 40, 6);
    chk("long_num", 32'(num), 32'h1203);
    chk("long_val", 32'(val), 32'hABCD);
    chk("long_cnt", 32'(we_seen - w0), 32'd1);

    // short frame
    w0 = we_seen; e0 = err_seen;
    send_frame(32'hDEAD_BEEF, 20, 6);
    chk("short_err", 32'(err_seen - e0), 32'd1);
    chk("short_we", 32'(we_seen - w0), 32'd0);
    chk("short_num", 32'(num), 32'h1203);
    chk("short_val", 32'(val), 32'hABCD);

    // reset mid-frame
    w0 = we_seen; e0 = err_seen;
    rxw = 32'h5A5A_5A5A;
    start_frame();
    for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)));
    do_reset();
    for (int i = 0; i < 22; i++) send_bit(1'($urandom_range(0, 1)));
    end_frame(6);
    chk("rst_we", 32'(we_seen - w0), 32'd0);
    chk("rst_err", 32'(err_seen - e0), 32'd0);
    chk("rst_num", 32'(num), 32'h0);
    send_frame(32'h0201_0005, 32, 6);
    chk("post_rst_num", 32'(num), 32'h0201);
    chk("post_rst_val", 32'(val), 32'h0005);

    // back-to-back with minimum gap
    w0 = we_seen;
    send_frame(32'h0A0A_1111, 32, S + 1);
    send_frame(32'h0B0B_2222, 32, S + 1);
    send_frame(32'h0C0C_3333, 32, S + 1);
    chk("b2b_cnt", 32'(we_seen - w0), 32'd3);
    chk("b2b_echo", got_miso, 32'h0B0B_2222);
    chk("b2b_num", 32'(num), 32'h0C0C);

    // randomized frames of random length and gap
    for (int k = 0; k < 25; k++)
      send_frame($urandom, int'($urandom_range(0, 40)), int'($urandom_range(S + 1, 8)));

    wait_n(20);
    chk("evq_empty", 32'(evq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
